// File: rtl/mod_reduce_pkg.sv
// Shared constants for the modular-reduction controller.
// State encodings and operand sizing live here.
package mod_reduce_pkg;

    localparam int WIDTH = 8;
    localparam int CNT_W = 3;
    localparam logic [WIDTH-1:0] ERR_QUOT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/comp_8bit.sv
// Combinational 8-bit unsigned magnitude comparator.
module comp_8bit (
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic       o_gt,
    output logic       o_eq,
    output logic       o_lt
);

    assign o_gt = (i_a > i_b);
    assign o_eq = (i_a == i_b);
    assign o_lt = (i_a < i_b);

endmodule

// File: rtl/mod_reduce_ctrl.sv
// Restoring shift-compare-subtract divider: quotient and remainder
// of an 8-bit dividend by an 8-bit modulus, one bit per cycle.
module mod_reduce_ctrl
    import mod_reduce_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] modulus,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             err
);

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_n;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_t;
    logic [WIDTH-1:0] w_r_next;
    logic [WIDTH-1:0] w_q_next;
    logic             w_gt;
    logic             w_eq;
    logic             w_ge;
    logic             w_lt_unused;
    logic             w_msb_unused;

    // Partial remainder stays below 2^7 before the last shift, so its
    // top bit never carries into the shifted value.
    assign w_t          = {r_r[WIDTH-2:0], r_a_sh[WIDTH-1]};
    assign w_msb_unused = r_r[WIDTH-1];

    comp_8bit u_comp (
        .i_a  (w_t),
        .i_b  (r_n),
        .o_gt (w_gt),
        .o_eq (w_eq),
        .o_lt (w_lt_unused)
    );

    assign w_ge     = w_gt | w_eq;
    assign w_r_next = w_ge ? (w_t - r_n) : w_t;
    assign w_q_next = {r_q[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a_sh  <= '0;
            r_n     <= '0;
            r_r     <= '0;
            r_q     <= '0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            quot    <= '0;
            rem     <= '0;
            err     <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (modulus != '0) begin
                            r_a_sh  <= dividend;
                            r_n     <= modulus;
                            r_r     <= '0;
                            r_q     <= '0;
                            r_cnt   <= CNT_W'(WIDTH - 1);
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            r_state <= ST_RUN;
                        end else begin
                            quot    <= ERR_QUOT;
                            rem     <= dividend;
                            err     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_RUN: begin
                    r_r    <= w_r_next;
                    r_q    <= w_q_next;
                    r_a_sh <= {r_a_sh[WIDTH-2:0], 1'b0};
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == '0) begin
                        quot    <= w_q_next;
                        rem     <= w_r_next;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mod_reduce_ctrl.sv
// Bench for mod_reduce_ctrl: directed cases plus random operands
// checked against plain integer division.
module tb_mod_reduce_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] modulus;
    logic       busy;
    logic       done;
    logic [7:0] quot;
    logic [7:0] rem;
    logic       err;

    int n_cmp;
    int n_bad;

    logic [7:0] exp_q;
    logic [7:0] exp_r;
    logic       exp_e;

    mod_reduce_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .modulus  (modulus),
        .busy     (busy),
        .done     (done),
        .quot     (quot),
        .rem      (rem),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic model(input int d, input int m);
        if (m == 0) begin
            exp_q = 8'hFF;
            exp_r = 8'(d);
            exp_e = 1'b1;
        end else begin
            exp_q = 8'(d / m);
            exp_r = 8'(d % m);
            exp_e = 1'b0;
        end
    endtask

    // Issue one operation and follow it to completion.
    task automatic run_op(input string tag, input int d, input int m);
        int cyc;
        int nbusy;
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'(d);
        modulus  = 8'(m);
        @(posedge clk);
        #1;
        start    = 1'b0;
        dividend = 8'($urandom);
        modulus  = 8'($urandom);
        model(d, m);
        cyc   = 0;
        nbusy = 0;
        while (!done && cyc < 30) begin
            if (busy) nbusy++;
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, ".lat"}, cyc, (m == 0) ? 0 : 8);
        chk({tag, ".busy_cycles"}, nbusy, (m == 0) ? 0 : 8);
        chk({tag, ".busy_at_done"}, int'(busy), 0);
        chk({tag, ".quot"}, int'(quot), int'(exp_q));
        chk({tag, ".rem"}, int'(rem), int'(exp_r));
        chk({tag, ".err"}, int'(err), int'(exp_e));
        @(posedge clk);
        #1;
        chk({tag, ".done_pulse"}, int'(done), 0);
    endtask

    initial begin
        n_cmp    = 0;
        n_bad    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        modulus  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.busy", int'(busy), 0);
        chk("reset.done", int'(done), 0);
        chk("reset.quot", int'(quot), 0);
        chk("reset.rem", int'(rem), 0);
        chk("reset.err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;

        run_op("t1_200_13", 200, 13);
        run_op("t2_255_1", 255, 1);
        run_op("t2_7_9", 7, 9);
        run_op("t3_255_255", 255, 255);
        run_op("t3_254_200", 254, 200);
        run_op("t4_77_0", 77, 0);
        run_op("t4_20_6", 20, 6);

        // Starts during RUN and DONE must be ignored.
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        modulus  = 8'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd99;
        modulus  = 8'd7;
        @(negedge clk);
        start = 1'b0;
        chk("t5.hold_quot", int'(quot), int'(exp_q));
        chk("t5.hold_rem", int'(rem), int'(exp_r));
        begin
            int cyc;
            cyc = 0;
            while (!done && cyc < 30) begin
                @(negedge clk);
                cyc++;
            end
            chk("t5.done_seen", int'(done), 1);
        end
        model(200, 13);
        chk("t5.quot", int'(quot), int'(exp_q));
        chk("t5.rem", int'(rem), int'(exp_r));
        start    = 1'b1;
        dividend = 8'd99;
        modulus  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t5.no_restart", int'(busy), 0);
        chk("t5.keep_quot", int'(quot), int'(exp_q));
        chk("t5.keep_rem", int'(rem), int'(exp_r));

        // Asynchronous reset in the middle of a run.
        run_op("t6_pre_0", 50, 0);
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        modulus  = 8'd13;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("t6.busy", int'(busy), 0);
        chk("t6.done", int'(done), 0);
        chk("t6.quot", int'(quot), 0);
        chk("t6.rem", int'(rem), 0);
        chk("t6.err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        run_op("t6_100_10", 100, 10);

        for (int i = 0; i < 40; i++) begin
            int d;
            int m;
            d = int'($urandom_range(0, 255));
            m = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 255));
            run_op($sformatf("rnd%0d_%0d_%0d", i, d, m), d, m);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mod_reduce_ctrl.md
Name: mod_reduce_ctrl

Overview:
Sequential controller that computes quotient and remainder of an 8-bit dividend by an 8-bit modulus. It uses restoring shift-compare-subtract over one shared 8-bit magnitude comparator.
It is the modular-reduction engine for the RSA encode/decode path, where results are reduced mod n after each multiply step.
The datapath is one comparator instance, one 8-bit subtractor, a shift register and a 3-bit iteration counter, sequenced by a small FSM.

Parameters:
WIDTH, 8, operand width; fixed at 8 to match the comparator; other values unsupported.
CNT_W, 3, iteration counter width, equal to log2(WIDTH).

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request pulse; sampled only in IDLE
dividend  input  8  value to reduce; latched on accepted start
modulus  input  8  divisor n; latched on accepted start
busy  output  1  high while iterating
done  output  1  one-cycle pulse; quot/rem/err valid from this cycle
quot  output  8  quotient
rem  output  8  remainder (dividend mod modulus)
err  output  1  modulus was zero; held until next accepted start

Behaviour:
- Reset (async, active-high, any state, including mid-operation):
  - state=IDLE; busy=0, done=0, err=0; quot=8'h00, rem=8'h00; counter=0, internal shift/remainder registers=0.
- Registers: a_sh (dividend shift reg), n_r (latched modulus), r (partial remainder, 8b), q (quotient, 8b), cnt (CNT_W).
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge k, modulus!=0:
  - latch a_sh=dividend, n_r=modulus; r=0, q=0, cnt=7, err=0.
  - go to RUN; busy=1 after edge k.
- IDLE, start=1 at edge k, modulus==0:
  - quot=8'hFF, rem=dividend, err=1, done=1.
  - go to DONE; busy stays 0.
- RUN, each edge:
  - t = {r[6:0], a_sh[7]}. r<n_r<=255 and at most 7 prior bits have been consumed, so the shifted value always fits in 8 bits; no 9th bit is required.
  - Comparator inputs: a=t, b=n_r. If gt|eq: r=t-n_r, q={q[6:0],1}; else r=t, q={q[6:0],0}.
  - a_sh shifts left by 1; cnt decrements.
- RUN exit: at the edge where cnt==0, after the final iteration:
  - quot=q_next, rem=r_next, done=1, busy=0; go to DONE.
  - Latency: start edge k -> done high after edge k+8; exactly 8 RUN cycles.
- DONE: one cycle. Next edge clears done and goes to IDLE.
  - A start sampled in DONE is ignored; start must be presented in IDLE.
- Output hold: quot, rem and err hold their values until the next accepted start. quot/rem only update on the DONE transition.
- start while busy or in DONE: ignored, with no effect on operands or results. Operand inputs may change freely while busy.
- Comparator lt output is unused. The comparator is purely combinational and lies on the r->r path, which sets the single-cycle timing.
- Back-to-back throughput: one result per 10 cycles (start in IDLE, 8 RUN, 1 DONE).

Decomposition:
- Shared package constants: state encodings (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2), WIDTH=8, ERR_QUOT=8'hFF.
- Sub-modules: comp_8bit, one existing 8-bit comparator instance, unmodified. No new sub-module is needed; subtractor and FSM stay inline.

Test Plan:
1. rst high then low; start dividend=200, modulus=13 -> done exactly 8 cycles after start edge; quot=15, rem=5, err=0; busy high for 8 cycles.
2. dividend=255, modulus=1 -> quot=255, rem=0. Then dividend=7, modulus=9 -> quot=0, rem=7 (dividend<modulus boundary).
3. dividend=255, modulus=255 -> quot=1, rem=0. Then dividend=254, modulus=200 -> quot=1, rem=54 (equality and large-modulus paths).
4. modulus=0, dividend=77 -> done one cycle after start, busy never high, err=1, quot=8'hFF, rem=77. Next start 20 mod 6 -> err=0, quot=3, rem=2.
5. Start 200 mod 13, then pulse start with 99 mod 7 on cycle 3 of RUN and again in DONE -> both ignored; result quot=15, rem=5; previous outputs held until new done.
6. Assert rst on cycle 4 of RUN, asynchronously mid-cycle -> busy, done, quot, rem, err go to 0 immediately. After release, start 100 mod 10 -> quot=10, rem=0.
